// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data memory port between instruction fetch and load/store
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   fetchRequest/Address       fetch word read request (held until fetchGrant)
//   fetchGrant/Valid/Data      fetch command issued / returned instruction word
//   dataReadMode/WriteMode     load/store request modes (0 = none; read wins if both set)
//   dataAddress/WriteData      load/store address and store data
//   dataGrant/Valid/ReadData   data command issued / access complete / load data
//   memAddress/ReadMode/WriteMode/WriteData   memory command
//   memReadData                memory read data, valid READ_LATENCY cycles after command
//   stall                      a requester is waiting or a read is outstanding
// Optional feature macro MEM_ARBITER_STATS_EN adds fetchGrantCount, dataGrantCount,
// conflictCount (32-bit wrapping counters).

module mem_port_arbiter #(
    parameter int READ_LATENCY    = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchRequest,
    input  logic [31:0] fetchAddress,
    output logic        fetchGrant,
    output logic        fetchValid,
    output logic [31:0] fetchData,
    input  logic [2:0]  dataReadMode,
    input  logic [2:0]  dataWriteMode,
    input  logic [31:0] dataAddress,
    input  logic [31:0] dataWriteData,
    output logic        dataGrant,
    output logic        dataValid,
    output logic [31:0] dataReadData,
    output logic [31:0] memAddress,
    output logic [2:0]  memReadMode,
    output logic [2:0]  memWriteMode,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic        stall
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0] fetchGrantCount,
    output logic [31:0] dataGrantCount,
    output logic [31:0] conflictCount
`endif
);

    localparam logic [2:0] MODE_WORD  = 3'd3;
    localparam logic [3:0] LAT_LOAD   = 4'(READ_LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FETCH = 2'd1,
        WAIT_DATA  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  count;
    logic [3:0]  streak;

    logic data_req;
    logic data_is_read;
    logic fetch_wins;
    logic data_wins;
    logic read_done;

    assign data_req     = (dataReadMode != 3'd0) || (dataWriteMode != 3'd0);
    assign data_is_read = (dataReadMode != 3'd0);
    // Fetch only overrides a data request once the data streak has saturated.
    assign fetch_wins   = (state == IDLE) && fetchRequest && (!data_req || streak == STREAK_MAX);
    assign data_wins    = (state == IDLE) && data_req && !fetch_wins;
    assign read_done    = (count <= 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fetch_wins) begin
                    next_state = WAIT_FETCH;
                end else if (data_wins && data_is_read) begin
                    next_state = WAIT_DATA;
                end
            end
            WAIT_FETCH, WAIT_DATA: begin
                if (read_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fetchGrant   = 1'b0;
        fetchValid   = 1'b0;
        fetchData    = 32'd0;
        dataGrant    = 1'b0;
        dataValid    = 1'b0;
        dataReadData = 32'd0;
        memAddress   = 32'd0;
        memReadMode  = 3'd0;
        memWriteMode = 3'd0;
        memWriteData = 32'd0;
        case (state)
            IDLE: begin
                if (fetch_wins) begin
                    fetchGrant  = 1'b1;
                    memAddress  = fetchAddress;
                    memReadMode = MODE_WORD;
                end else if (data_wins) begin
                    dataGrant  = 1'b1;
                    memAddress = dataAddress;
                    if (data_is_read) begin
                        memReadMode = dataReadMode;
                    end else begin
                        // Writes complete in the grant cycle.
                        memWriteMode = dataWriteMode;
                        memWriteData = dataWriteData;
                        dataValid    = 1'b1;
                    end
                end
            end
            WAIT_FETCH: begin
                if (read_done) begin
                    fetchValid = 1'b1;
                    fetchData  = memReadData;
                end
            end
            WAIT_DATA: begin
                if (read_done) begin
                    dataValid    = 1'b1;
                    dataReadData = memReadData;
                end
            end
            default: ;
        endcase
    end

    assign stall = (fetchRequest && !fetchGrant) || (data_req && !dataGrant) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 4'd0;
            streak <= 4'd0;
        end else begin
            if (fetchGrant || (dataGrant && data_is_read)) begin
                count <= LAT_LOAD;
            end else if (state != IDLE && count != 4'd0) begin
                count <= count - 4'd1;
            end

            if (!fetchRequest || fetchGrant) begin
                streak <= 4'd0;
            end else if (dataGrant && streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchGrantCount <= 32'd0;
            dataGrantCount  <= 32'd0;
            conflictCount   <= 32'd0;
        end else begin
            if (fetchGrant) fetchGrantCount <= fetchGrantCount + 32'd1;
            if (dataGrant)  dataGrantCount  <= dataGrantCount + 32'd1;
            if (state == IDLE && fetchRequest && data_req) conflictCount <= conflictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int L = 2;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchGrant;
    logic        fetchValid;
    logic [31:0] fetchData;
    logic [2:0]  dataReadMode;
    logic [2:0]  dataWriteMode;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic        dataGrant;
    logic        dataValid;
    logic [31:0] dataReadData;
    logic [31:0] memAddress;
    logic [2:0]  memReadMode;
    logic [2:0]  memWriteMode;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        stall;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] fetchGrantCount;
    logic [31:0] dataGrantCount;
    logic [31:0] conflictCount;
`endif

    mem_port_arbiter #(.READ_LATENCY(L), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
        .fetchGrant(fetchGrant), .fetchValid(fetchValid), .fetchData(fetchData),
        .dataReadMode(dataReadMode), .dataWriteMode(dataWriteMode),
        .dataAddress(dataAddress), .dataWriteData(dataWriteData),
        .dataGrant(dataGrant), .dataValid(dataValid), .dataReadData(dataReadData),
        .memAddress(memAddress), .memReadMode(memReadMode), .memWriteMode(memWriteMode),
        .memWriteData(memWriteData), .memReadData(memReadData), .stall(stall)
`ifdef MEM_ARBITER_STATS_EN
        , .fetchGrantCount(fetchGrantCount), .dataGrantCount(dataGrantCount),
        .conflictCount(conflictCount)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h2402000A;
        return (a ^ 32'h5A5A0000) + 32'h11;
    endfunction

    // Memory model: returns mem_fn(address) L cycles after the command.
    logic [31:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= memAddress;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign memReadData = mem_fn(pipe[L-1]);

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          when;
    } exp_t;

    exp_t fetch_q[$];
    exp_t data_q[$];
    int   n_fetch_grants = 0;
    int   n_data_grants = 0;
    int   n_conflicts = 0;

    // Scoreboard: expected read results are queued at grant time, checked on valid.
    always @(negedge clk) begin
        if (rst) begin
            fetch_q.delete();
            data_q.delete();
            n_fetch_grants = 0;
            n_data_grants = 0;
            n_conflicts = 0;
        end else begin
            if (fetchRequest && (dataReadMode != 0 || dataWriteMode != 0) && (fetchGrant || dataGrant))
                n_conflicts++;
            if (fetchGrant) begin
                n_fetch_grants++;
                fetch_q.push_back('{mem_fn(fetchAddress), cyc + L});
            end
            if (dataGrant) begin
                n_data_grants++;
                if (dataReadMode != 0)
                    data_q.push_back('{mem_fn(dataAddress), cyc + L});
                else
                    check_eq("sb_write_valid", {31'd0, dataValid}, 32'd1);
            end
            if (fetchValid) begin
                if (fetch_q.size() == 0) begin
                    check_eq("sb_fetch_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = fetch_q.pop_front();
                    check_eq("sb_fetch_data", fetchData, e.data);
                    check_eq("sb_fetch_cycle", cyc, e.when);
                end
            end
            if (dataValid && !dataGrant) begin
                if (data_q.size() == 0) begin
                    check_eq("sb_data_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = data_q.pop_front();
                    check_eq("sb_data_data", dataReadData, e.data);
                    check_eq("sb_data_cycle", cyc, e.when);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        fetchRequest = 1'b0; fetchAddress = 32'd0;
        dataReadMode = 3'd0; dataWriteMode = 3'd0;
        dataAddress = 32'd0; dataWriteData = 32'd0;
        for (int i = 0; i < L; i++) pipe[i] = 32'd0;

        next_cycle();
        sample();
        check_eq("rst_fetchGrant", {31'd0, fetchGrant}, 32'd0);
        check_eq("rst_dataGrant", {31'd0, dataGrant}, 32'd0);
        check_eq("rst_valids", {30'd0, fetchValid, dataValid}, 32'd0);
        check_eq("rst_memAddress", memAddress, 32'd0);
        check_eq("rst_modes", {26'd0, memReadMode, memWriteMode}, 32'd0);
        check_eq("rst_memWriteData", memWriteData, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);

        // Lone fetch of 0x100.
        next_cycle();
        rst = 1'b0;
        fetchRequest = 1'b1; fetchAddress = 32'h100;
        sample();
        check_eq("f_grant", {31'd0, fetchGrant}, 32'd1);
        check_eq("f_memReadMode", {29'd0, memReadMode}, 32'd3);
        check_eq("f_memAddress", memAddress, 32'h100);
        check_eq("f_stall_T", {31'd0, stall}, 32'd0);
        next_cycle();
        fetchRequest = 1'b0;
        sample();
        check_eq("f_stall_T1", {31'd0, stall}, 32'd1);
        check_eq("f_valid_T1", {31'd0, fetchValid}, 32'd0);
        check_eq("f_memReadMode_wait", {29'd0, memReadMode}, 32'd0);
        next_cycle();
        sample();
        check_eq("f_valid_T2", {31'd0, fetchValid}, 32'd1);
        check_eq("f_data_T2", fetchData, 32'h2402000A);
        next_cycle();
        fetchRequest = 1'b1; fetchAddress = 32'h104;
        sample();
        check_eq("f_regrant_T3", {31'd0, fetchGrant}, 32'd1);
        next_cycle();
        fetchRequest = 1'b0;
        next_cycle();
        next_cycle();

        // Simultaneous fetch and data WORD read: data first.
        fetchRequest = 1'b1; fetchAddress = 32'h108;
        dataReadMode = 3'd3; dataAddress = 32'h200;
        sample();
        check_eq("c_dataGrant", {31'd0, dataGrant}, 32'd1);
        check_eq("c_fetchGrant", {31'd0, fetchGrant}, 32'd0);
        check_eq("c_memAddress", memAddress, 32'h200);
        check_eq("c_stall_T", {31'd0, stall}, 32'd1);
        next_cycle();
        dataReadMode = 3'd0;
        sample();
        check_eq("c_stall_T1", {31'd0, stall}, 32'd1);
        check_eq("c_fetchGrant_T1", {31'd0, fetchGrant}, 32'd0);
        next_cycle();
        sample();
        check_eq("c_stall_T2", {31'd0, stall}, 32'd1);
        check_eq("c_dataValid_T2", {31'd0, dataValid}, 32'd1);
        next_cycle();
        sample();
        check_eq("c_fetchGrant_T3", {31'd0, fetchGrant}, 32'd1);
        check_eq("c_memAddress_T3", memAddress, 32'h108);
        next_cycle();
        fetchRequest = 1'b0;
        sample();
        check_eq("c_stall_T4", {31'd0, stall}, 32'd1);
        next_cycle();
        next_cycle();

        // Streak limit: fetch held against continuous SW stores, two rounds.
        for (int r = 0; r < 2; r++) begin
            fetchRequest = 1'b1; fetchAddress = 32'h10C;
            dataWriteMode = 3'd3; dataAddress = 32'h600;
            for (int i = 0; i <= MAXS; i++) begin
                dataWriteData = 32'hC0DE0000 + 32'(i);
                sample();
                if (i < MAXS) begin
                    check_eq($sformatf("s%0d_dataGrant%0d", r, i), {31'd0, dataGrant}, 32'd1);
                    check_eq($sformatf("s%0d_memWriteData%0d", r, i), memWriteData, 32'hC0DE0000 + 32'(i));
                    check_eq($sformatf("s%0d_fetchGrant%0d", r, i), {31'd0, fetchGrant}, 32'd0);
                end else begin
                    check_eq($sformatf("s%0d_fetchGrant_last", r), {31'd0, fetchGrant}, 32'd1);
                    check_eq($sformatf("s%0d_dataGrant_last", r), {31'd0, dataGrant}, 32'd0);
                end
                next_cycle();
            end
            fetchRequest = 1'b0; dataWriteMode = 3'd0;
            next_cycle();
            next_cycle();
        end

        // SB to 0x303, then a second store the next cycle.
        dataWriteMode = 3'd1; dataAddress = 32'h303; dataWriteData = 32'hAB;
        sample();
        check_eq("sb_grant", {31'd0, dataGrant}, 32'd1);
        check_eq("sb_valid", {31'd0, dataValid}, 32'd1);
        check_eq("sb_memWriteMode", {29'd0, memWriteMode}, 32'd1);
        check_eq("sb_memAddress", memAddress, 32'h303);
        check_eq("sb_memWriteData", memWriteData, 32'hAB);
        check_eq("sb_memReadMode", {29'd0, memReadMode}, 32'd0);
        next_cycle();
        dataAddress = 32'h304; dataWriteData = 32'hCD;
        sample();
        check_eq("sb2_grant", {31'd0, dataGrant}, 32'd1);
        check_eq("sb2_memWriteData", memWriteData, 32'hCD);
        next_cycle();
        dataWriteMode = 3'd0;
        sample();
        check_eq("idle_stall", {31'd0, stall}, 32'd0);
        check_eq("idle_memAddress", memAddress, 32'd0);

        // Reset one cycle into WAIT_DATA.
        next_cycle();
        dataReadMode = 3'd3; dataAddress = 32'h400;
        sample();
        check_eq("r_dataGrant", {31'd0, dataGrant}, 32'd1);
        next_cycle();
        dataReadMode = 3'd0; rst = 1'b1;
        sample();
        check_eq("r_dataValid_rst", {31'd0, dataValid}, 32'd0);
        next_cycle();
        rst = 1'b0;
        fetchRequest = 1'b1; fetchAddress = 32'h500;
        sample();
        check_eq("r_fetchGrant_after", {31'd0, fetchGrant}, 32'd1);
        check_eq("r_dataValid_after", {31'd0, dataValid}, 32'd0);
        check_eq("r_memAddress_after", memAddress, 32'h500);
        next_cycle();
        fetchRequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq($sformatf("r_no_dataValid%0d", i), {31'd0, dataValid}, 32'd0);
            next_cycle();
        end
        sample();
        check_eq("end_stall", {31'd0, stall}, 32'd0);
        check_eq("end_fetch_q_empty", 32'(fetch_q.size()), 32'd0);
        check_eq("end_data_q_empty", 32'(data_q.size()), 32'd0);
`ifdef MEM_ARBITER_STATS_EN
        check_eq("stats_fetchGrantCount", fetchGrantCount, 32'(n_fetch_grants));
        check_eq("stats_dataGrantCount", dataGrantCount, 32'(n_data_grants));
        check_eq("stats_conflictCount", conflictCount, 32'(n_conflicts));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
